// File: rtl/counter_pkg.sv
// Shared definitions for the counter_10state phase bus and its receive-side monitor.
package counter_pkg;

  localparam int STATE_W            = 4;
  localparam int DEFAULT_LAST_STATE = 9;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  // Successor of a phase index in a 0..last sequence.
  function automatic logic [STATE_W-1:0] next_phase(input logic [STATE_W-1:0] cur,
                                                    input logic [STATE_W-1:0] last);
    if (cur == last) begin
      next_phase = {STATE_W{1'b0}};
    end else begin
      next_phase = cur + STATE_W'(1);
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event tally with clear priority; saturates at all-ones when SAT=1, otherwise wraps.
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic         at_max_s;

  assign at_max_s = (count_r == {W{1'b1}});

  // Count register: clear beats increment, saturation blocks increment at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && !(SAT && at_max_s)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/counter_10state_monitor.sv
// Receive-side checker for a mod-N phase bus: acquires, locks after clean wraps,
// then reports each wrap and each sequence error with saturating/rolling tallies.
module counter_10state_monitor
  import counter_pkg::*;
#(
  parameter int LAST_STATE = DEFAULT_LAST_STATE,
  parameter int LOCK_WRAPS = 2,
  parameter int ERR_W      = 8,
  parameter int WRAP_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [STATE_W-1:0]   i_state,
  input  logic                 i_transition,
  input  logic                 i_clr,
  output logic                 o_locked,
  output logic                 o_wrap,
  output logic                 o_err,
  output logic [ERR_W-1:0]     o_err_count,
  output logic [WRAP_W-1:0]    o_wrap_count,
  output logic [STATE_W-1:0]   o_expected
);

  localparam int GOOD_W = (LOCK_WRAPS < 2) ? 1 : $clog2(LOCK_WRAPS + 1);
  localparam logic [STATE_W-1:0] LAST      = STATE_W'(LAST_STATE);
  localparam logic [STATE_W-1:0] FIRST_EXP = (LAST_STATE == 0) ? STATE_W'(0) : STATE_W'(1);
  localparam logic [GOOD_W-1:0]  LOCK_N    = GOOD_W'(LOCK_WRAPS);

  mon_state_e          state_r, state_n;
  logic [STATE_W-1:0]  exp_r, exp_n;
  logic [GOOD_W-1:0]   good_r, good_n;
  logic [GOOD_W-1:0]   good_inc_s;
  logic                locked_r, wrap_r, err_r;
  logic                match_s, wrap_s, err_s, exp_zero_s;

  assign exp_zero_s = (exp_r == {STATE_W{1'b0}});
  assign good_inc_s = good_r + GOOD_W'(1);
  // exp_r never exceeds LAST, but the range check keeps the intent explicit.
  assign match_s = (i_state <= LAST) && (i_state == exp_r) && (i_transition == exp_zero_s);

  // Next-state, expected-phase and pulse decode.
  always_comb begin
    state_n = state_r;
    exp_n   = exp_r;
    good_n  = good_r;
    wrap_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      SEARCH: begin
        if ((i_state == {STATE_W{1'b0}}) && i_transition) begin
          state_n = ACQUIRE;
          exp_n   = FIRST_EXP;
          good_n  = {GOOD_W{1'b0}};
        end else begin
          state_n = SEARCH;
        end
      end
      ACQUIRE: begin
        if (match_s) begin
          exp_n = next_phase(exp_r, LAST);
          if (exp_zero_s && (good_inc_s == LOCK_N)) begin
            state_n = LOCKED;
            good_n  = {GOOD_W{1'b0}};
          end else if (exp_zero_s) begin
            good_n = good_inc_s;
          end else begin
            good_n = good_r;
          end
        end else begin
          state_n = SEARCH;
          exp_n   = {STATE_W{1'b0}};
          good_n  = {GOOD_W{1'b0}};
        end
      end
      LOCKED: begin
        if (match_s) begin
          exp_n  = next_phase(exp_r, LAST);
          wrap_s = exp_zero_s;
        end else begin
          err_s   = 1'b1;
          state_n = SEARCH;
          exp_n   = {STATE_W{1'b0}};
          good_n  = {GOOD_W{1'b0}};
        end
      end
      default: begin
        state_n = SEARCH;
        exp_n   = {STATE_W{1'b0}};
        good_n  = {GOOD_W{1'b0}};
      end
    endcase
  end

  // Tracking state and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= SEARCH;
      exp_r    <= {STATE_W{1'b0}};
      good_r   <= {GOOD_W{1'b0}};
      locked_r <= 1'b0;
      wrap_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      exp_r    <= exp_n;
      good_r   <= good_n;
      locked_r <= (state_n == LOCKED);
      wrap_r   <= wrap_s;
      err_r    <= err_s;
    end
  end

  sat_counter #(.W(ERR_W), .SAT(1'b1)) u_err_count (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_clr),
    .inc   (err_s),
    .count (o_err_count)
  );

  sat_counter #(.W(WRAP_W), .SAT(1'b0)) u_wrap_count (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_clr),
    .inc   (wrap_s),
    .count (o_wrap_count)
  );

  assign o_locked   = locked_r;
  assign o_wrap     = wrap_r;
  assign o_err      = err_r;
  assign o_expected = exp_r;

endmodule

// File: tb/tb_counter_10state_monitor.sv
// Directed bench for counter_10state_monitor (ERR_W=2 so saturation is reachable).
module tb_counter_10state_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  st;
  logic        tr;
  logic        clr;
  logic        o_locked, o_wrap, o_err;
  logic [1:0]  o_err_count;
  logic [15:0] o_wrap_count;
  logic [3:0]  o_expected;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;

  counter_10state_monitor #(
    .LAST_STATE(9), .LOCK_WRAPS(2), .ERR_W(2), .WRAP_W(16)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_state      (st),
    .i_transition (tr),
    .i_clr        (clr),
    .o_locked     (o_locked),
    .o_wrap       (o_wrap),
    .o_err        (o_err),
    .o_err_count  (o_err_count),
    .o_wrap_count (o_wrap_count),
    .o_expected   (o_expected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // One sample per call; outputs are examined 1ns after the capturing edge.
  task automatic drive(input logic [3:0] s, input logic t);
    st = s;
    tr = t;
    @(posedge clk);
    #1;
  endtask

  // Model of an upstream mod-10 phase counter.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      drive(4'(ph), ph == 0);
      ph = (ph == 9) ? 0 : ph + 1;
    end
  endtask

  task automatic relock();
    while (ph != 0) feed(1);
    feed(20);
    check("relock_pre", 32'(o_locked), 32'd0);
    feed(1);
    check("relock", 32'(o_locked), 32'd1);
  endtask

  task automatic inject_err(input int want_cnt);
    drive(4'(ph), ph != 0);
    ph = (ph == 9) ? 0 : ph + 1;
    check("err_pulse", 32'(o_err), 32'd1);
    check("err_unlock", 32'(o_locked), 32'd0);
    check("err_count", 32'(o_err_count), 32'(want_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(o_locked), 32'd0);
    check({tag, "_wrap"}, 32'(o_wrap), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_errcnt"}, 32'(o_err_count), 32'd0);
    check({tag, "_wrapcnt"}, 32'(o_wrap_count), 32'd0);
    check({tag, "_exp"}, 32'(o_expected), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    st    = 4'd0;
    tr    = 1'b0;
    clr   = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Upstream still in reset: (0,0) is ignored in SEARCH.
    drive(4'd0, 1'b0);
    check("search_idle_lock", 32'(o_locked), 32'd0);
    check("search_idle_err", 32'(o_err), 32'd0);

    // Clean lock.
    ph = 0;
    feed(20);
    check("lock_k19", 32'(o_locked), 32'd0);
    check("lock_k19_exp", 32'(o_expected), 32'd0);
    feed(1);
    check("lock_k20", 32'(o_locked), 32'd1);
    check("lock_k20_exp", 32'(o_expected), 32'd1);
    check("lock_no_wrap", 32'(o_wrap), 32'd0);
    feed(9);
    check("wrap_k29", 32'(o_wrap), 32'd0);
    feed(1);
    check("wrap_k30", 32'(o_wrap), 32'd1);
    check("wrapcnt_1", 32'(o_wrap_count), 32'd1);
    feed(40);
    check("wrap_k70", 32'(o_wrap), 32'd1);
    check("wrapcnt_5", 32'(o_wrap_count), 32'd5);
    check("errcnt_clean", 32'(o_err_count), 32'd0);
    feed(1);
    check("wrap_one_cycle", 32'(o_wrap), 32'd0);

    // Skipped state: 6 where 5 is expected.
    feed(3);
    check("skip_exp5", 32'(o_expected), 32'd5);
    drive(4'd6, 1'b0);
    check("skip_err", 32'(o_err), 32'd1);
    check("skip_unlock", 32'(o_locked), 32'd0);
    check("skip_errcnt", 32'(o_err_count), 32'd1);
    check("skip_exp0", 32'(o_expected), 32'd0);
    drive(4'd7, 1'b0);
    check("skip_err_once", 32'(o_err), 32'd0);
    ph = 8;
    relock();

    // Clear during lock: counts zero, FSM untouched.
    clr = 1'b1;
    feed(1);
    clr = 1'b0;
    check("clr_errcnt", 32'(o_err_count), 32'd0);
    check("clr_wrapcnt", 32'(o_wrap_count), 32'd0);
    check("clr_keeps_lock", 32'(o_locked), 32'd1);

    // Strobe faults: strobe at state 4, then missing strobe at state 0.
    feed(2);
    inject_err(1);
    relock();
    feed(9);
    drive(4'd0, 1'b0);
    ph = 1;
    check("nostrobe_err", 32'(o_err), 32'd1);
    check("nostrobe_errcnt", 32'(o_err_count), 32'd2);
    check("nostrobe_unlock", 32'(o_locked), 32'd0);

    // Saturation at 3, then clear coinciding with the 6th error.
    clr = 1'b1;
    feed(1);
    clr = 1'b0;
    check("sat_clr", 32'(o_err_count), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      relock();
      inject_err((e > 3) ? 3 : e);
    end
    relock();
    clr = 1'b1;
    inject_err(0);
    clr = 1'b0;
    feed(1);
    check("clr_err_after", 32'(o_err), 32'd0);
    check("clr_errcnt_after", 32'(o_err_count), 32'd0);

    // Mid-cycle asynchronous reset while LOCKED.
    relock();
    feed(9);
    feed(1);
    check("pre_rst_wrapcnt", 32'(o_wrap_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    feed(3);
    check("post_rst_lock", 32'(o_locked), 32'd0);
    check("post_rst_exp", 32'(o_expected), 32'd0);

    // Out-of-range state during ACQUIRE is dropped silently.
    while (ph != 0) feed(1);
    feed(1);
    check("acq_exp1", 32'(o_expected), 32'd1);
    feed(4);
    check("acq_exp5", 32'(o_expected), 32'd5);
    drive(4'd12, 1'b0);
    ph = 6;
    check("oor_no_err", 32'(o_err), 32'd0);
    check("oor_exp0", 32'(o_expected), 32'd0);
    check("oor_unlock", 32'(o_locked), 32'd0);
    relock();
    check("final_errcnt", 32'(o_err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
